// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-path constants and the buffered {pc, instr} entry layout.
// Also the single home of the data width, ROM depth and default reset PC.
package if_fetch_unit_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned ROM_DEPTH        = 1024;
  localparam int unsigned PC_W             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush; full/empty and head data are combinational views
// of the pointer/storage registers.
module if_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wptr == rptr);
  assign full_c  = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign do_pop  = pop & ~empty_c;
  // A full FIFO may still accept a push when its head leaves in the same cycle.
  assign do_push = push & (~full_c | do_pop);
  assign rdata_c = mem[rptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (PTR_W+1)'(1);
      if (do_pop)  rptr <= rptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch between the ROM and the core: sequential PC, prefetch FIFO,
// and redirect-driven flush/refetch.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W     = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fetch_en_i,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [31:0]           instr_pc_o
);

  logic [31:0]  fetch_pc;
  logic         full_c;
  logic         empty_c;
  logic         push_c;
  logic         pop_c;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  assign rom_addr_o    = fetch_pc[ADDR_W+1:2];
  assign instr_valid_o = ~empty_c;
  assign pop_c         = instr_valid_o & instr_ready_i;
  assign push_c        = fetch_en_i & ~redirect_i & (~full_c | pop_c);
  assign wr_entry      = '{pc: fetch_pc, instr: rom_data_i};
  assign instr_o       = instr_valid_o ? rd_entry.instr : '0;
  assign instr_pc_o    = instr_valid_o ? rd_entry.pc    : '0;

  // Redirect wins over sequential advance and aligns the target to a word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & ~32'd3;
    end else if (push_c) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (redirect_i),
    .push    (push_c),
    .wdata   (wr_entry),
    .pop     (pop_c),
    .rdata_c (rd_entry),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; the ROM returns its word address as data.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int unsigned AW = $clog2(ROM_DEPTH);

  logic                  clk;
  logic                  rstn;
  logic                  fetch_en_i;
  logic [AW-1:0]         rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;
  logic                  redirect_i;
  logic [31:0]           redirect_pc_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [31:0]           instr_pc_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] xfer_q [$];

  if_fetch_unit dut (
    .clk           (clk),
    .rstn          (rstn),
    .fetch_en_i    (fetch_en_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data_i = DATA_WIDTH'(rom_addr_o);

  // Log every handshake so duplicates or lost entries show up in the order.
  always @(posedge clk) begin
    if (rstn && instr_valid_o && instr_ready_i) xfer_q.push_back(instr_pc_o);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins);
    check({tag, ".valid"}, 64'(instr_valid_o), 64'(v));
    check({tag, ".pc"},    64'(instr_pc_o),    64'(pc));
    check({tag, ".instr"}, 64'(instr_o),       64'(ins));
  endtask

  task automatic check_xfer(input string tag, input logic [31:0] exp [$]);
    check({tag, ".count"}, 64'(xfer_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < xfer_q.size(); i++)
      check($sformatf("%s.pc%0d", tag, i), 64'(xfer_q[i]), 64'(exp[i]));
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    fetch_en_i    = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    step();
    step();
    xfer_q.delete();
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_head("reset", 1'b0, 32'h0, 32'h0);
    check("reset.rom_addr", 64'(rom_addr_o), 64'h0);

    // Streaming: one instruction per cycle, valid from the cycle after the first edge
    fetch_en_i    = 1'b1;
    instr_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_head($sformatf("stream%0d", k), 1'b1, 32'(4 * k), 32'(k));
    end

    // Back-pressure: fill to depth, PC frozen, head stable, then drain with no gap
    do_reset();
    fetch_en_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_head($sformatf("stall%0d", k), 1'b1, 32'h0, 32'h0);
    end
    check("stall.rom_addr", 64'(rom_addr_o), 64'h2);
    instr_ready_i = 1'b1;
    step();
    check_head("drain0", 1'b1, 32'h4, 32'h1);
    step();
    check_head("drain1", 1'b1, 32'h8, 32'h2);
    step();
    check_xfer("drain", '{32'h0, 32'h4, 32'h8});

    // Redirect while full: bubble, then target word only
    do_reset();
    fetch_en_i = 1'b1;
    step();
    step();
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0042;
    step();
    redirect_i = 1'b0;
    check_head("redir.bubble", 1'b0, 32'h0, 32'h0);
    step();
    check_head("redir.target", 1'b1, 32'h40, 32'd16);
    instr_ready_i = 1'b1;
    step();
    check_head("redir.next", 1'b1, 32'h44, 32'd17);
    check_xfer("redir", '{32'h40});

    // Redirect with fetch disabled, then PC wrap at the top of the address space
    do_reset();
    fetch_en_i    = 1'b1;
    instr_ready_i = 1'b1;
    step();
    fetch_en_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    check("wrap.rom_hi", 64'(rom_addr_o), 64'h3FF);
    check_head("wrap.flush", 1'b0, 32'h0, 32'h0);
    step();
    check("wrap.hold", 64'(rom_addr_o), 64'h3FF);
    fetch_en_i = 1'b1;
    step();
    check_head("wrap.top", 1'b1, 32'hFFFF_FFFC, 32'h3FF);
    check("wrap.rom_zero", 64'(rom_addr_o), 64'h0);
    step();
    check_head("wrap.zero", 1'b1, 32'h0, 32'h0);

    // Asynchronous reset mid-stream with two buffered entries
    do_reset();
    fetch_en_i = 1'b1;
    step();
    step();
    step();
    rstn = 1'b0;
    #1;
    check_head("areset", 1'b0, 32'h0, 32'h0);
    check("areset.rom_addr", 64'(rom_addr_o), 64'h0);
    rstn = 1'b1;
    step();
    check_head("areset.restart", 1'b1, 32'h0, 32'h0);

    // Pop and redirect in the same cycle
    do_reset();
    fetch_en_i    = 1'b1;
    instr_ready_i = 1'b1;
    step();
    step();
    step();
    check_head("popredir.pre", 1'b1, 32'h8, 32'h2);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    step();
    redirect_i = 1'b0;
    check("popredir.bubble", 64'(instr_valid_o), 64'h0);
    step();
    check_head("popredir.t0", 1'b1, 32'h100, 32'h40);
    step();
    check_head("popredir.t1", 1'b1, 32'h104, 32'h41);
    check_xfer("popredir", '{32'h0, 32'h4, 32'h8, 32'h100});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter FIFO_DEPTH, default 2; number of buffered {pc, instr} entries (power of two, at least 2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000; byte address fetched first after reset.
REQ-003 Parameter ADDR_W, default $clog2(`ROM_DEPTH); ROM word-address width.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rstn, input, 1: asynchronous, active-low reset.
REQ-006 Port fetch_en_i, input, 1: 1 = fetching permitted; 0 = hold fetch PC, no FIFO push.
REQ-007 Port rom_addr_o, output, ADDR_W: ROM word address.
REQ-008 Port rom_data_i, input, `DATA_WIDTH: ROM instruction word, combinational in rom_addr_o.
REQ-009 Port redirect_i, input, 1: branch/jump taken; flush and refetch.
REQ-010 Port redirect_pc_i, input, 32: redirect target byte address.
REQ-011 Port instr_valid_o, output, 1: head entry valid toward the core decode stage.
REQ-012 Port instr_ready_i, input, 1: core accepts the head entry.
REQ-013 Port instr_o, output, `DATA_WIDTH: head instruction.
REQ-014 Port instr_pc_o, output, 32: byte PC of the head instruction.

Function
REQ-015 fetch_pc register; rom_addr_o SHALL equal fetch_pc[ADDR_W+1:2], combinationally.
REQ-016 push = fetch_en_i & !redirect_i & (!full | pop), where pop = instr_valid_o & instr_ready_i.
- On push, {fetch_pc, rom_data_i} is written to the FIFO tail.
- On push, fetch_pc increments by 4.
REQ-017 fetch_pc SHALL wrap modulo 2^32; rom_addr_o wraps modulo ROM_DEPTH by truncation.
REQ-018 instr_valid_o = FIFO not empty; instr_o/instr_pc_o = head entry when valid, else 0.
REQ-019 Pop on a cycle with valid & ready. On a full FIFO, pop and push in the same cycle are legal and occupancy is unchanged.
REQ-020 Once valid is asserted, instr_o and instr_pc_o SHALL stay stable until popped or flushed.
REQ-021 redirect_i=1 in cycle T: the pop in cycle T, if any, still counts as transferred.
- All remaining entries are flushed at the T edge.
- No push occurs in cycle T.
- fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
REQ-022 After redirect in cycle T: instr_valid_o=0 in T+1; target instruction valid in T+2 (if fetch_en_i=1 in T+1).
REQ-023 redirect_i has priority over fetch_en_i. A redirect while fetch_en_i=0 still flushes and loads fetch_pc.
REQ-024 Back-to-back redirects: the last one wins; no entry from an earlier target is ever presented.
REQ-025 Throughput: one instruction per cycle sustained while ready=1 and no redirect.

Reset
REQ-026 While rstn=0: fetch_pc=RESET_PC, FIFO empty, instr_valid_o=0, instr_o=0, instr_pc_o=0, rom_addr_o=RESET_PC[ADDR_W+1:2].
REQ-027 Reset assertion mid-operation SHALL discard all buffered entries immediately, asynchronously.
REQ-028 Timing after rstn deasserts with fetch_en_i=1: first edge pushes RESET_PC; instr_valid_o=1 in the following cycle.

Structure
REQ-029 `DATA_WIDTH, `ROM_DEPTH, and the default reset PC live in the shared defines.v; no local redefinition.
REQ-030 The FIFO SHALL be a sub-module if_fifo: synchronous FIFO with flush input, full/empty flags, and FIFO_DEPTH/WIDTH parameters.
REQ-031 The block sits between rom and rv_core; rv_core instr_i/instr_addr_o connect through it.

Verification
REQ-032 Reset then ready=1 with ROM word[k]=k -> instr_pc_o 0,4,8,… with instr_o 0,1,2,…, one per cycle, valid from cycle 2.
REQ-033 ready=0 for 5 cycles -> FIFO fills to 2; fetch_pc frozen at 8; instr_o stays 0 (pc 0); release gives pcs 0,4,8 with no gap or duplicate.
REQ-034 Redirect to 0x0000_0042 while full -> valid=0 next cycle; next valid entry has pc 0x40, instr=ROM[16]; old entries never seen.
REQ-035 fetch_pc starting at 0xFFFF_FFFC -> next pc 0x0000_0000; rom_addr_o wraps to 0.
REQ-036 rstn pulsed low mid-stream with FIFO holding 2 entries -> valid drops to 0 immediately; restart from RESET_PC.
REQ-037 Pop and redirect in the same cycle -> popped entry counted once; subsequent entries come only from the target.
